// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode map, arbiter state encoding and the
// worst-case FPU latency the arbiter's timeout must exceed.
package fpu_pkg;

    localparam logic [4:0] FPU_FADD    = 5'd0;
    localparam logic [4:0] FPU_FSUB    = 5'd1;
    localparam logic [4:0] FPU_FMUL    = 5'd2;
    localparam logic [4:0] FPU_FDIV    = 5'd3;
    localparam logic [4:0] FPU_FMIN    = 5'd4;
    localparam logic [4:0] FPU_FMAX    = 5'd5;
    localparam logic [4:0] FPU_FEQ     = 5'd6;
    localparam logic [4:0] FPU_FLT     = 5'd7;
    localparam logic [4:0] FPU_FLE     = 5'd8;
    localparam logic [4:0] FPU_FCVTW   = 5'd9;
    localparam logic [4:0] FPU_FCVTWU  = 5'd10;
    localparam logic [4:0] FPU_FCVTS   = 5'd11;
    localparam logic [4:0] FPU_FNEG    = 5'd12;
    localparam logic [4:0] FPU_FABS    = 5'd13;
    localparam logic [4:0] FPU_FSGNJ   = 5'd14;
    localparam logic [4:0] FPU_FSGNJN  = 5'd15;
    localparam logic [4:0] FPU_FSGNJX  = 5'd16;
    localparam logic [4:0] FPU_FCLASS  = 5'd17;
    localparam logic [4:0] FPU_FMVXW   = 5'd18;
    localparam logic [4:0] FPU_FMVWX   = 5'd19;
    localparam logic [4:0] FPU_FSQR    = 5'd20;

    localparam int FPU_CTL_MAX     = 20;
    // fdiv takes 6 stages plus the issue cycle
    localparam int FPU_MAX_LATENCY = 7;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_RESP  = 3'd3,
        ARB_ERR   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found_s;
    int   idx_s;

    // walk the requests in priority order starting at ptr
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s        = (int'(ptr) + k) % N;
            grant[idx_s] = req[idx_s] & ~found_s;
            found_s      = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU between NREQ requesters: round-robin accept, one op in
// flight, one-cycle response with error for illegal opcodes and lost ready.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    parameter int CTL_MAX = FPU_CTL_MAX
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_ctl,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_y,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 fpu_en,
    output logic [4:0]           fpu_ctl,
    output logic [31:0]          fpu_x1,
    output logic [31:0]          fpu_x2,
    input  logic                 fpu_ready,
    input  logic [31:0]          fpu_y
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // never let the timeout undercut the slowest FPU op
    localparam int TO_EFF = (TIMEOUT > FPU_MAX_LATENCY) ? TIMEOUT : FPU_MAX_LATENCY + 1;
    localparam int CW = $clog2(TO_EFF);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TO_EFF - 1);
    localparam logic [4:0]      CTL_LIMIT = 5'(CTL_MAX);
    localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

    arb_state_e      state_r, state_s;
    logic [PW-1:0]   ptr_r, owner_r, owner_s, owner_nx_s;
    logic [4:0]      ctl_r, sel_ctl_s;
    logic [31:0]     x1_r, x2_r, sel_x1_s, sel_x2_s;
    logic [CW-1:0]   cnt_r;
    logic [NREQ-1:0] grant_s, resp_valid_r;
    logic [31:0]     resp_y_r;
    logic            resp_err_r, fpu_en_r, xfer_s;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s)
    );

    // decode the winning requester and mux its operands
    always_comb begin
        owner_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_s = owner_s | (grant_s[i] ? PW'(i) : '0);
        end
        xfer_s     = (state_r == ARB_IDLE) && rstn && (|grant_s);
        owner_nx_s = xfer_s ? owner_s : owner_r;
        sel_ctl_s  = req_ctl[5*int'(owner_s) +: 5];
        sel_x1_s   = req_x1[32*int'(owner_s) +: 32];
        sel_x2_s   = req_x2[32*int'(owner_s) +: 32];
    end

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (xfer_s) begin
                    state_s = (sel_ctl_s > CTL_LIMIT) ? ARB_ERR : ARB_ISSUE;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: state_s = ARB_WAIT;
            ARB_WAIT: begin
                if (fpu_ready) begin
                    state_s = ARB_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ARB_ERR;
                end else begin
                    state_s = ARB_WAIT;
                end
            end
            ARB_RESP: state_s = ARB_IDLE;
            ARB_ERR:  state_s = ARB_IDLE;
            default:  state_s = ARB_IDLE;
        endcase
    end

    // state, timeout counter and registered response/start outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= ARB_IDLE;
            cnt_r        <= '0;
            fpu_en_r     <= 1'b0;
            resp_valid_r <= '0;
            resp_err_r   <= 1'b0;
            resp_y_r     <= 32'd0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= ((state_r == ARB_WAIT) && (state_s == ARB_WAIT)) ? cnt_r + CW'(1) : '0;
            fpu_en_r     <= (state_s == ARB_ISSUE);
            resp_valid_r <= ((state_s == ARB_RESP) || (state_s == ARB_ERR)) ? (ONE_HOT0 << owner_nx_s) : '0;
            resp_err_r   <= (state_s == ARB_ERR);
            if ((state_r == ARB_WAIT) && fpu_ready) begin
                resp_y_r <= fpu_y;
            end else if (state_s == ARB_ERR) begin
                resp_y_r <= 32'd0;
            end
        end
    end

    // operand latches and round-robin pointer, updated on each transfer
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_r   <= '0;
            owner_r <= '0;
            ctl_r   <= 5'd0;
            x1_r    <= 32'd0;
            x2_r    <= 32'd0;
        end else if (xfer_s) begin
            ptr_r   <= (owner_s == PW'(NREQ - 1)) ? '0 : owner_s + PW'(1);
            owner_r <= owner_s;
            ctl_r   <= sel_ctl_s;
            x1_r    <= sel_x1_s;
            x2_r    <= sel_x2_s;
        end
    end

    assign req_ready  = xfer_s ? grant_s : '0;
    assign resp_valid = resp_valid_r;
    assign resp_y     = resp_y_r;
    assign resp_err   = resp_err_r;
    assign busy       = (state_r != ARB_IDLE);
    assign fpu_en     = fpu_en_r;
    assign fpu_ctl    = ctl_r;
    assign fpu_x1     = x1_r;
    assign fpu_x2     = x2_r;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a behavioural FPU whose latency and
// result are set per test; expected values are hand-computed constants.
module tb_fpu_arbiter;
    import fpu_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NREQ-1:0]     req_valid, req_ready, resp_valid;
    logic [5*NREQ-1:0]   req_ctl;
    logic [32*NREQ-1:0]  req_x1, req_x2;
    logic [31:0]         resp_y, fpu_x1, fpu_x2, fpu_y;
    logic                resp_err, busy, fpu_en, fpu_ready;
    logic [4:0]          fpu_ctl;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          fpu_lat, m_lat, rdy_seen, rdy_base;
    logic [31:0] fpu_res, m_res;
    logic        fpu_dead, quiet;

    always #5 clk = ~clk;

    fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CTL_MAX(FPU_CTL_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ctl(req_ctl), .req_x1(req_x1), .req_x2(req_x2),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_y(resp_y), .resp_err(resp_err),
        .busy(busy), .fpu_en(fpu_en), .fpu_ctl(fpu_ctl), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_ready(fpu_ready), .fpu_y(fpu_y)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]         = 1'b1;
        req_ctl[5*i +: 5]    = c;
        req_x1[32*i +: 32]   = a;
        req_x2[32*i +: 32]   = b;
    endtask

    // one operation: wait for the handshake, then follow it to its response
    task automatic op(input string tag, input logic [1:0] egnt, input int ewait, input logic keep,
                      input logic [4:0] ectl, input logic [31:0] ex1, input logic [31:0] ex2,
                      input int lat, input logic [31:0] res,
                      input logic [31:0] ey, input logic ee, input int eenc, input int elat);
        int w, cyc, n_en;
        logic [1:0] g;
        logic hold_ok;
        fpu_lat = lat;
        fpu_res = res;
        #1;
        w = 0;
        while ((req_valid & req_ready) == 2'b00 && w < 8) begin
            tick();
            w++;
        end
        g = req_valid & req_ready;
        check_eq({tag, "_gnt"}, 32'(g), 32'(egnt));
        check_eq({tag, "_wait"}, w, ewait);
        cyc = 0;
        n_en = 0;
        hold_ok = 1'b1;
        do begin
            tick();
            cyc++;
            if (cyc == 1 && !keep) req_valid = req_valid & ~g;
            if (fpu_en) n_en++;
            if (busy && resp_valid == 2'b00 &&
                (fpu_ctl !== ectl || fpu_x1 !== ex1 || fpu_x2 !== ex2)) hold_ok = 1'b0;
        end while (resp_valid == 2'b00 && cyc < 40);
        check_eq({tag, "_rvalid"}, 32'(resp_valid), 32'(egnt));
        check_eq({tag, "_y"}, resp_y, ey);
        check_eq({tag, "_err"}, 32'(resp_err), 32'(ee));
        check_eq({tag, "_en_cnt"}, n_en, eenc);
        check_eq({tag, "_latency"}, cyc, elat);
        check_eq({tag, "_hold"}, 32'(hold_ok), 32'd1);
    endtask

    // behavioural FPU: ready one cycle after issue plus m_lat stages
    initial begin
        fpu_ready = 1'b0;
        fpu_y     = 32'd0;
        forever begin
            tick();
            if (fpu_en && !fpu_dead) begin
                m_res = fpu_res;
                m_lat = fpu_lat;
                @(posedge clk);
                repeat (m_lat) @(posedge clk);
                #1;
                fpu_ready = 1'b1;
                fpu_y     = m_res;
                tick();
                fpu_ready = 1'b0;
                fpu_y     = 32'd0;
            end
        end
    end

    always @(posedge clk) begin
        if (fpu_ready) rdy_seen <= rdy_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rdy_seen  = 0;
        rstn      = 1'b0;
        req_valid = '0;
        req_ctl   = '0;
        req_x1    = '0;
        req_x2    = '0;
        fpu_dead  = 1'b0;
        fpu_lat   = 0;
        fpu_res   = 32'd0;
        repeat (3) tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp", {resp_y[30:0], resp_err}, 32'd0);
        check_eq("rst_fpu", {fpu_en, fpu_ctl, fpu_x1[25:0]}, 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        rstn = 1'b1;
        tick();

        // single fadd 1.0 + 2.0
        drive(0, FPU_FADD, 32'h3F800000, 32'h40000000);
        op("t1_fadd", 2'b01, 0, 1'b0, FPU_FADD, 32'h3F800000, 32'h40000000,
           2, 32'h40400000, 32'h40400000, 1'b0, 1, 5);

        // illegal opcode from req1, back-to-back after the fadd response
        drive(1, 5'd25, 32'h11111111, 32'h22222222);
        op("t4_ill", 2'b10, 1, 1'b0, 5'd25, 32'h11111111, 32'h22222222,
           0, 32'd0, 32'd0, 1'b1, 0, 1);
        tick();
        check_eq("t4_idle", 32'(busy), 32'd0);

        // contention: both hold fmul 2.0*3.0, grants must alternate
        drive(0, FPU_FMUL, 32'h40000000, 32'h40C00000);
        drive(1, FPU_FMUL, 32'h40000000, 32'h40C00000);
        op("t2_a", 2'b01, 0, 1'b1, FPU_FMUL, 32'h40000000, 32'h40C00000, 3, 32'h40C00000, 32'h40C00000, 1'b0, 1, 6);
        op("t2_b", 2'b10, 1, 1'b1, FPU_FMUL, 32'h40000000, 32'h40C00000, 3, 32'h40C00000, 32'h40C00000, 1'b0, 1, 6);
        op("t2_c", 2'b01, 1, 1'b1, FPU_FMUL, 32'h40000000, 32'h40C00000, 3, 32'h40C00000, 32'h40C00000, 1'b0, 1, 6);
        op("t2_d", 2'b10, 1, 1'b1, FPU_FMUL, 32'h40000000, 32'h40C00000, 3, 32'h40C00000, 32'h40C00000, 1'b0, 1, 6);
        req_valid = '0;

        // zero-stage fneg, then immediate fabs (pointer wraps back to req0)
        drive(0, FPU_FNEG, 32'h3F800000, 32'h00000000);
        op("t3_fneg", 2'b01, 1, 1'b0, FPU_FNEG, 32'h3F800000, 32'h00000000,
           0, 32'hBF800000, 32'hBF800000, 1'b0, 1, 3);
        drive(0, FPU_FABS, 32'hBF800000, 32'h00000000);
        op("t3_fabs", 2'b01, 1, 1'b0, FPU_FABS, 32'hBF800000, 32'h00000000,
           0, 32'h3F800000, 32'h3F800000, 1'b0, 1, 3);

        // lost ready pulse: error 16 cycles after entering WAIT
        fpu_dead = 1'b1;
        drive(1, FPU_FADD, 32'h3F800000, 32'h40000000);
        op("t5_to", 2'b10, 1, 1'b0, FPU_FADD, 32'h3F800000, 32'h40000000,
           0, 32'h12345678, 32'd0, 1'b1, 1, 18);
        fpu_dead = 1'b0;
        drive(0, FPU_FADD, 32'h3F800000, 32'h40000000);
        op("t5_fadd", 2'b01, 1, 1'b0, FPU_FADD, 32'h3F800000, 32'h40000000,
           2, 32'h40400000, 32'h40400000, 1'b0, 1, 5);

        // reset during an fdiv 6.0/2.0 issued by req0
        fpu_lat = 6;
        fpu_res = 32'h40400000;
        drive(0, FPU_FDIV, 32'h40C00000, 32'h40000000);
        tick();
        check_eq("t6_gnt", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        check_eq("t6_busy_pre", 32'(busy), 32'd1);
        rstn = 1'b0;
        tick();
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_fpu", {fpu_en, fpu_ctl, fpu_x1[25:0]}, 32'd0);
        check_eq("t6_rst_x2", fpu_x2, 32'd0);
        check_eq("t6_rst_resp", {resp_valid, resp_err, resp_y[28:0]}, 32'd0);
        rstn = 1'b1;
        rdy_base = rdy_seen;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (resp_valid != 2'b00 || busy) quiet = 1'b0;
        end
        check_eq("t6_quiet", 32'(quiet), 32'd1);
        check_eq("t6_late_ready", rdy_seen - rdy_base, 32'd1);
        drive(0, FPU_FADD, 32'h3F800000, 32'h40000000);
        drive(1, FPU_FADD, 32'h3F800000, 32'h40000000);
        op("t6_next", 2'b01, 0, 1'b0, FPU_FADD, 32'h3F800000, 32'h40000000,
           2, 32'h40400000, 32'h40400000, 1'b0, 1, 5);
        req_valid = '0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
Shares one FPU instance between NREQ requesters, for example an integer-pipe FP issue and a vector/helper unit. It accepts one request at a time under round-robin priority. It latches the opcode and operands, pulses the FPU enable and then holds ctl/x1/x2 stable until the FPU ready pulse. The result is returned to the owning requester as a one-cycle response, with error reporting for illegal opcodes and lost ready pulses.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before the op is aborted with error (>= 8, above the longest FPU latency)
CTL_MAX, 20, highest legal FPU opcode; ctl > CTL_MAX is illegal

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  NREQ  request pending, per requester
req_ctl  in  5*NREQ  opcode, requester i at bits [5i+4:5i]
req_x1  in  32*NREQ  operand 1, requester i at bits [32i+31:32i]
req_x2  in  32*NREQ  operand 2, same packing
req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i]
resp_valid  out  NREQ  one-hot, one-cycle result pulse to the owner
resp_y  out  32  result, valid while any resp_valid bit is set
resp_err  out  1  qualifies resp_valid: illegal opcode or timeout
busy  out  1  high in every state except IDLE
fpu_en  out  1  one-cycle start pulse to FPU
fpu_ctl  out  5  opcode to FPU, held for the whole operation
fpu_x1  out  32  operand 1 to FPU, held
fpu_x2  out  32  operand 2 to FPU, held
fpu_ready  in  1  FPU one-cycle completion pulse
fpu_y  in  32  FPU result, valid with fpu_ready

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, req_ready=0, resp_valid=0, resp_y=0, resp_err=0, fpu_en=0, fpu_ctl/x1/x2=0, rr pointer=0 (requester 0 has highest priority), timeout counter=0.
- Reset mid-operation aborts the op with no response. After reset the FPU is treated as idle; the block does not wait for a stale fpu_ready.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. ERR is reached from IDLE (illegal opcode) or WAIT (timeout), then goes to IDLE.
- IDLE: req_ready is combinational. Exactly one bit is set: the first req_valid at or after the rr pointer, wrapping modulo NREQ. No bit is set if no request is valid.
- IDLE: on a transfer, latch owner, ctl, x1 and x2, and set the rr pointer to owner+1 mod NREQ.
- IDLE -> ERR if the latched ctl > CTL_MAX. No fpu_en is issued.
- IDLE -> ISSUE otherwise.
- ISSUE: fpu_en=1 for exactly this cycle, then go to WAIT. fpu_ctl/x1/x2 are driven from the latches from ISSUE through RESP.
- WAIT: the timeout counter increments every cycle.
- WAIT, fpu_ready=1: register fpu_y into resp_y and go to RESP.
- WAIT, counter reaches TIMEOUT-1 without fpu_ready: go to ERR.
- WAIT: fpu_ready arriving on the same cycle as the timeout wins, giving a normal response.
- RESP: resp_valid[owner]=1 and resp_err=0 for one cycle, then IDLE.
- ERR: resp_valid[owner]=1, resp_err=1, resp_y=0 for one cycle, then IDLE.
- Latency from transfer cycle T: fpu_en at T+1, result at (fpu_ready cycle)+1. Zero-stage ops return at T+3.
- Back-to-back: a new transfer is possible in the cycle after RESP/ERR, giving at most one op in flight.
- Responses have no backpressure; requesters must sink resp_valid.
- fpu_ready seen outside WAIT is ignored.
- req_ready is 0 in every state except IDLE.
- Requesters hold valid/ctl/x1/x2 until accepted. Changing them while unaccepted is permitted; the values sampled at the transfer are used.

Decomposition:
- Shared package fpu_pkg holds:
  - opcode localparams FPU_FADD=0 .. FPU_FSQR=20 and FPU_CTL_MAX=20;
  - arbiter state encoding (IDLE, ISSUE, WAIT, RESP, ERR);
  - FPU_MAX_LATENCY=7 (fdiv 6 + issue), used to check TIMEOUT.
- One sub-module: rr_arbiter. Parameter N; inputs req[N], ptr; output grant[N] one-hot. It is purely combinational; the pointer register lives in fpu_arbiter.

Test Plan:
1. Single fadd: req0 ctl=0, x1=0x3F800000, x2=0x40000000. Expect one fpu_en pulse, fpu_ctl held at 0 until fpu_ready, then resp_valid=01, resp_y=0x40400000, resp_err=0.
2. Contention fairness, with both valid continuously, fmul 2.0*3.0 (0x40000000, 0x40C00000): grants alternate req0, req1, req0, req1. Each response is 0x40C00000 on the correct one-hot resp_valid. There is never more than one fpu_en per operation.
3. Zero-latency fneg: ctl=12, x1=0x3F800000. Expect resp_y=0xBF800000 at transfer+3. Then an immediate back-to-back fabs of 0xBF800000 returns 0x3F800000.
4. Illegal opcode: ctl=25 from req1. Expect no fpu_en, resp_valid=10, resp_err=1, resp_y=0, then the arbiter returns to IDLE.
5. Timeout: the FPU model never pulses ready, TIMEOUT=16. Expect resp_err=1 exactly 16 cycles after entering WAIT. A subsequent fadd completes normally.
6. Reset mid-WAIT: rstn=0 for one cycle during an fdiv. Expect all outputs zero, no response for the aborted op, and a late fpu_ready ignored. The next request is granted to req0 first.
